// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered adder among NREQ requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module adder_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic [2*NREQ-1:0]       f_i,
  input  logic [WIDTH*NREQ-1:0]   a_i,
  input  logic [WIDTH*NREQ-1:0]   b_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [1:0]              add_f_o,
  output logic [WIDTH-1:0]        add_a_o,
  output logic [WIDTH-1:0]        add_b_o,
  input  logic [WIDTH-1:0]        add_y_i,
  output logic [NREQ-1:0]         resp_valid_o,
  output logic [WIDTH-1:0]        resp_y_o,
  input  logic [NREQ-1:0]         resp_ready_i,
  output logic                    busy_o
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] owner, sel, base, idx;
  logic [1:0] cnt;
  logic hit, done;
  assign done = state == RESP && resp_ready_i[owner];
  assign busy_o = state != IDLE;
  // first set request at or above base, wrapping around
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(base) + i) % NREQ);
      if (!hit && req_i[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE  ? (hit ? ISSUE : IDLE)
             : state == ISSUE ? WAIT
             : state == WAIT  ? (cnt == 2'd0 ? RESP : WAIT)
             : (done ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gnt_o <= '0;
      owner <= '0;
      add_f_o <= '0;
      add_a_o <= '0;
      add_b_o <= '0;
      cnt <= '0;
      resp_valid_o <= '0;
      resp_y_o <= '0;
    end else begin
      gnt_o <= '0;
      if (state == IDLE && hit) begin
        gnt_o <= NREQ'(1) << sel;
        owner <= sel;
        add_f_o <= 2'(f_i >> (2 * sel));
        add_a_o <= WIDTH'(a_i >> (WIDTH * sel));
        add_b_o <= WIDTH'(b_i >> (WIDTH * sel));
      end
      if (state == ISSUE) cnt <= 2'(ADDER_LAT - 1);
      if (state == WAIT) begin
        if (cnt == 2'd0) begin
          resp_y_o <= add_y_i;
          resp_valid_o <= NREQ'(1) << owner;
        end else cnt <= cnt - 2'd1;
      end
      if (done) resp_valid_o <= '0;
    end
`ifdef ADDER_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IW-1:0] ptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (done) ptr <= owner == IW'(NREQ - 1) ? '0 : owner + 1'b1;
  assign base = ptr;
`endif
endmodule
